// File: rtl/dmem_copy_sched_if.sv
// Data-memory port bundle: read/write strobes, address and store data.
// The side that issues the access uses master, the side that receives it uses slave.
interface dmem_copy_sched_if;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (
    output re,
    output we,
    output addr,
    output wdata
  );

  modport slave (
    input re,
    input we,
    input addr,
    input wdata
  );
endinterface

// File: rtl/dmem_copy_sched.sv
// Arbitrates the data-memory port between the MEM stage and a copy engine
// that snapshots NUM_WORDS sensor words into a fixed memory window.
module dmem_copy_sched #(
  parameter int unsigned NUM_WORDS = 27,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned PERIOD    = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     copy_req,
  input  logic                     auto_en,
  output logic [4:0]               src_idx,
  input  logic [31:0]              src_data,
  dmem_copy_sched_if.slave         cpu,
  dmem_copy_sched_if.master        mem,
  output logic                     cpu_stall,
  output logic                     busy,
  output logic                     done,
  output logic                     conflict
);

  localparam int unsigned TW = $clog2(PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);
  localparam logic [4:0] LAST = 5'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COPY,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [4:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic          req_q;
  logic          conflict_q;

  logic          req_edge;
  logic          auto_hit;
  logic          start;

  logic          re_c;
  logic          we_c;
  logic [31:0]   addr_c;
  logic [31:0]   wdata_c;
  logic [4:0]    idx_c;
  logic          stall_c;
  logic          busy_c;
  logic          done_c;

  assign req_edge = copy_req & ~req_q;
  assign auto_hit = auto_en & (timer_q == '0);
  assign start    = (state_q == IDLE) & (req_edge | auto_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      timer_q    <= RELOAD;
      req_q      <= copy_req;
      conflict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= copy_req;
      if (state_q == COPY) begin
        if (cnt_q != LAST)
          cnt_q <= cnt_q + 5'd1;
        if (cpu.re | cpu.we)
          conflict_q <= 1'b1;
      end else begin
        cnt_q <= '0;
      end
      // Outside IDLE the timer simply holds its reloaded value.
      if (state_q == IDLE) begin
        if (!auto_en || timer_q == '0 || start)
          timer_q <= RELOAD;
        else
          timer_q <= timer_q - TW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    re_c    = cpu.re;
    we_c    = cpu.we;
    addr_c  = cpu.addr;
    wdata_c = cpu.wdata;
    idx_c   = '0;
    stall_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = DRAIN;
      end
      DRAIN: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        state_d = COPY;
      end
      COPY: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        re_c    = 1'b0;
        we_c    = 1'b1;
        idx_c   = cnt_q;
        wdata_c = src_data;
        addr_c  = BASE_ADDR + {25'd0, cnt_q, 2'b00};
        if (cnt_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        done_c  = 1'b1;
        re_c    = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every output low in the very cycle it is applied.
  always_comb begin
    mem.re    = re_c & ~rst;
    mem.we    = we_c & ~rst;
    mem.addr  = rst ? 32'd0 : addr_c;
    mem.wdata = rst ? 32'd0 : wdata_c;
    src_idx   = rst ? 5'd0 : idx_c;
    cpu_stall = stall_c & ~rst;
    busy      = busy_c & ~rst;
    done      = done_c & ~rst;
    conflict  = conflict_q & ~rst;
  end

endmodule

// File: tb/tb_dmem_copy_sched.sv
// Directed-plus-random bench for dmem_copy_sched against a cycle-offset
// reference model of a snapshot copy.
module tb_dmem_copy_sched;

  localparam int N = 27;
  localparam int P = 64;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        copy_req = 1'b0;
  logic        auto_en = 1'b0;
  logic [4:0]  src_idx;
  logic [31:0] src_data;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic        conflict;
  logic [31:0] axi [32];
  logic [31:0] dmem [256];

  dmem_copy_sched_if cpu_if ();
  dmem_copy_sched_if mem_if ();

  dmem_copy_sched #(
    .NUM_WORDS(N),
    .BASE_ADDR(BASE),
    .PERIOD(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .copy_req(copy_req),
    .auto_en(auto_en),
    .src_idx(src_idx),
    .src_data(src_data),
    .cpu(cpu_if),
    .mem(mem_if),
    .cpu_stall(cpu_stall),
    .busy(busy),
    .done(done),
    .conflict(conflict)
  );

  always #5 clk = ~clk;
  always_comb src_data = axi[src_idx];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: m_off = cycles since acceptance (0 drain, 1..N writes, N+1 done).
  int   m_off = -1;
  int   m_timer = P - 1;
  int   m_writes = 0;
  int   m_dones = 0;
  logic m_prev = 1'b0;
  logic m_conf = 1'b0;

  int   d_writes = 0;
  int   d_dones = 0;
  int   mcyc = 0;
  int   done_t[$];

  always @(posedge clk) begin
    mcyc++;
    if (mem_if.we) dmem[mem_if.addr[9:2]] = mem_if.wdata;
    if (mem_if.we && busy && mem_if.addr >= BASE &&
        mem_if.addr < BASE + 32'(4 * N))
      d_writes++;
    if (done) begin
      d_dones++;
      done_t.push_back(mcyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int i;
    if (rst) begin
      chk("rst_re", 32'(mem_if.re), 0);
      chk("rst_we", 32'(mem_if.we), 0);
      chk("rst_addr", mem_if.addr, 0);
      chk("rst_wdata", mem_if.wdata, 0);
      chk("rst_src", 32'(src_idx), 0);
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_conf", 32'(conflict), 0);
      return;
    end
    if (m_off <= 0) begin
      chk("pt_re", 32'(mem_if.re), 32'(cpu_if.re));
      chk("pt_we", 32'(mem_if.we), 32'(cpu_if.we));
      chk("pt_addr", mem_if.addr, cpu_if.addr);
      chk("pt_wdata", mem_if.wdata, cpu_if.wdata);
      chk("pt_src", 32'(src_idx), 0);
      chk("pt_stall", 32'(cpu_stall), 32'(m_off == 0));
      chk("pt_busy", 32'(busy), 32'(m_off == 0));
      chk("pt_done", 32'(done), 0);
    end else if (m_off <= N) begin
      i = m_off - 1;
      chk("cp_re", 32'(mem_if.re), 0);
      chk("cp_we", 32'(mem_if.we), 1);
      chk("cp_addr", mem_if.addr, BASE + 32'(4 * i));
      chk("cp_wdata", mem_if.wdata, axi[i]);
      chk("cp_src", 32'(src_idx), 32'(i));
      chk("cp_stall", 32'(cpu_stall), 1);
      chk("cp_busy", 32'(busy), 1);
      chk("cp_done", 32'(done), 0);
    end else begin
      chk("dn_re", 32'(mem_if.re), 0);
      chk("dn_we", 32'(mem_if.we), 0);
      chk("dn_src", 32'(src_idx), 0);
      chk("dn_stall", 32'(cpu_stall), 1);
      chk("dn_busy", 32'(busy), 1);
      chk("dn_done", 32'(done), 1);
    end
    chk("conflict", 32'(conflict), 32'(m_conf));
  endtask

  task automatic model_update();
    logic trig;
    if (rst) begin
      m_off = -1;
      m_timer = P - 1;
      m_conf = 1'b0;
    end else if (m_off < 0) begin
      trig = (copy_req && !m_prev) || (auto_en && m_timer == 0);
      if (!auto_en || m_timer == 0 || trig) m_timer = P - 1;
      else m_timer--;
      if (trig) m_off = 0;
    end else begin
      if (m_off >= 1 && m_off <= N) begin
        m_writes++;
        if (cpu_if.re || cpu_if.we) m_conf = 1'b1;
      end
      if (m_off == N + 1) begin
        m_dones++;
        m_off = -1;
      end else begin
        m_off++;
      end
    end
    m_prev = copy_req;
  endtask

  task automatic step(input logic r, input logic req, input logic ae,
                      input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r;
    copy_req = req;
    auto_en = ae;
    cpu_if.re = rd;
    cpu_if.we = wr;
    cpu_if.addr = a;
    cpu_if.wdata = d;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  // CPU traffic stays below the copy window so it never aliases copy data.
  task automatic run(input int n, input logic req, input logic ae,
                     input logic rnd);
    for (int k = 0; k < n; k++) begin
      if (rnd)
        step(1'b0, req, ae, 1'($urandom), 1'($urandom),
             32'($urandom_range(0, 63)) << 2, $urandom);
      else
        step(1'b0, req, ae, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic fill_axi();
    for (int i = 0; i < 32; i++) axi[i] = $urandom;
  endtask

  int w0;
  int d0;
  int tries;

  initial begin
    cpu_if.re = 1'b0;
    cpu_if.we = 1'b0;
    cpu_if.addr = '0;
    cpu_if.wdata = '0;
    for (int i = 0; i < 32; i++) axi[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h77);
    run(6, 1'b0, 1'b0, 1'b1);

    // Manual copy, CPU store completing in the drain cycle.
    w0 = d_writes;
    d0 = d_dones;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("drain_enter", 32'(m_off), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h55);
    run(N + 4, 1'b1, 1'b0, 1'b0);
    chk("m1_writes", 32'(d_writes - w0), 32'(N));
    chk("m1_dones", 32'(d_dones - d0), 1);
    chk("m1_store", dmem[16], 32'h55);
    chk("m1_first", dmem[64], 32'hA000_0000);
    chk("m1_last", dmem[64 + N - 1], 32'hA000_001A);
    chk("m1_conf", 32'(conflict), 0);

    // Level held, dropped and re-raised mid-copy: one copy only.
    fill_axi();
    run(2, 1'b0, 1'b0, 1'b0);
    w0 = d_writes;
    d0 = d_dones;
    run(9, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    run(N + 10, 1'b1, 1'b0, 1'b0);
    chk("hold_writes", 32'(d_writes - w0), 32'(N));
    chk("hold_dones", 32'(d_dones - d0), 1);

    // CPU store injected on copy word 5 raises a sticky conflict.
    fill_axi();
    run(2, 1'b0, 1'b0, 1'b0);
    run(7, 1'b1, 1'b0, 1'b0);
    chk("cf_word5", 32'(m_off), 6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'hDEAD);
    chk("cf_set", 32'(m_conf), 1);
    run(N + 8, 1'b0, 1'b0, 1'b0);
    chk("cf_sticky", 32'(conflict), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("cf_clear", 32'(conflict), 0);

    // Reset at copy word 10 abandons the copy; next request is complete.
    fill_axi();
    run(1, 1'b0, 1'b0, 1'b0);
    d0 = d_dones;
    run(12, 1'b1, 1'b0, 1'b0);
    chk("rs_word10", 32'(m_off), 11);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run(3, 1'b1, 1'b0, 1'b0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_nodone", 32'(d_dones - d0), 0);
    w0 = d_writes;
    run(2, 1'b0, 1'b0, 1'b0);
    run(N + 4, 1'b1, 1'b0, 1'b0);
    chk("rs_writes", 32'(d_writes - w0), 32'(N));
    chk("rs_dones", 32'(d_dones - d0), 1);

    // Periodic refresh with random CPU traffic.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    fill_axi();
    done_t.delete();
    run(3 * (P + N + 2) + 20, 1'b0, 1'b1, 1'b1);
    chk("auto_count", 32'(done_t.size()), 3);
    for (int k = 1; k < done_t.size(); k++)
      chk("auto_period", 32'(done_t[k] - done_t[k-1]), 32'(P + N + 2));

    // Manual edge landing on the timer-expiry cycle: single copy.
    tries = 0;
    while (!(m_off < 0 && m_timer == 0) && tries < 300) begin
      run(1, 1'b0, 1'b1, 1'b0);
      tries++;
    end
    chk("coinc_found", 32'(tries < 300), 1);
    w0 = d_writes;
    d0 = d_dones;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    run(N + 3, 1'b1, 1'b1, 1'b0);
    chk("coinc_writes", 32'(d_writes - w0), 32'(N));
    chk("coinc_dones", 32'(d_dones - d0), 1);

    chk("tot_writes", 32'(d_writes), 32'(m_writes));
    chk("tot_dones", 32'(d_dones), 32'(m_dones));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
